// File: rtl/mshr_replay_pkg.sv
// mshr_replay_pkg
//   Shared types and helpers for the MSHR replay stage: micro-op/request
//   structs, branch-update struct, FSM state enum, branch-mask helpers,
//   the kill predicate and the saturating counter increment used by the
//   optional performance counters (MSHR_REPLAY_PERF_EN).
package mshr_replay_pkg;

  localparam int BR_W       = 8;
  localparam int PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [BR_W-1:0] br_mask;
    logic            uses_ldq;
    logic [5:0]      rob_idx;
  } micro_op_t;

  typedef struct packed {
    micro_op_t   uop;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [BR_W-1:0] resolve_mask;
  } br_resolve_t;

  typedef struct packed {
    br_resolve_t b1;
  } br_update_t;

  function automatic logic [BR_W-1:0] get_new_br_mask(input br_update_t bu,
                                                      input logic [BR_W-1:0] mask);
    return mask & ~bu.b1.resolve_mask;
  endfunction

  function automatic logic is_killed_by_branch(input br_update_t bu,
                                               input logic [BR_W-1:0] mask);
    return |(mask & bu.b1.resolve_mask);
  endfunction

  // A held request dies on any resolving branch it depends on, or on an
  // LSU flush if it is a load-queue user.
  function automatic logic kill_now(input br_update_t bu, input logic flush,
                                    input micro_op_t uop);
    return is_killed_by_branch(bu, uop.br_mask) || (flush && uop.uses_ldq);
  endfunction

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mshr_replay_stage_if.sv
// mshr_replay_stage_if
//   Bundles the replay-stage request/issue/status signals.
//   slave  : the replay stage side (consumes io_in_*, drives io_out_*/pulses).
//   master : the environment side (upstream queue + data array).
//   Ports: io_brupdate, io_flush, io_in_valid/ready/bits, io_out_valid/ready/
//   bits, io_nack, io_done, io_drop, io_killed, io_busy and, when
//   MSHR_REPLAY_PERF_EN is defined, io_perf_issued/nacked/killed.
interface mshr_replay_stage_if
  import mshr_replay_pkg::*;
#(parameter type T = req_t);

  br_update_t io_brupdate;
  logic       io_flush;
  logic       io_in_valid;
  logic       io_in_ready;
  T           io_in_bits;
  logic       io_out_valid;
  logic       io_out_ready;
  T           io_out_bits;
  logic       io_nack;
  logic       io_done;
  logic       io_drop;
  logic       io_killed;
  logic       io_busy;
`ifdef MSHR_REPLAY_PERF_EN
  logic [PERF_CNT_W-1:0] io_perf_issued;
  logic [PERF_CNT_W-1:0] io_perf_nacked;
  logic [PERF_CNT_W-1:0] io_perf_killed;

  modport slave (
    input  io_brupdate, io_flush, io_in_valid, io_in_bits, io_out_ready, io_nack,
    output io_in_ready, io_out_valid, io_out_bits, io_done, io_drop, io_killed, io_busy,
    output io_perf_issued, io_perf_nacked, io_perf_killed
  );
  modport master (
    output io_brupdate, io_flush, io_in_valid, io_in_bits, io_out_ready, io_nack,
    input  io_in_ready, io_out_valid, io_out_bits, io_done, io_drop, io_killed, io_busy,
    input  io_perf_issued, io_perf_nacked, io_perf_killed
  );
`else
  modport slave (
    input  io_brupdate, io_flush, io_in_valid, io_in_bits, io_out_ready, io_nack,
    output io_in_ready, io_out_valid, io_out_bits, io_done, io_drop, io_killed, io_busy
  );
  modport master (
    output io_brupdate, io_flush, io_in_valid, io_in_bits, io_out_ready, io_nack,
    input  io_in_ready, io_out_valid, io_out_bits, io_done, io_drop, io_killed, io_busy
  );
`endif

endinterface

// File: rtl/mshr_replay_nack_timer.sv
// mshr_replay_nack_timer
//   Countdown from NACK_LAT-1 loaded on an issue handshake; window is high
//   while the count is zero, which (while run is held) is exactly NACK_LAT
//   cycles after the load cycle.
//   Ports: clock, reset (sync, active-low), start (load), run (count down),
//   window (nack window strobe).
module mshr_replay_nack_timer #(
  parameter int NACK_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic window
);

  localparam int WAIT_W = (NACK_LAT > 1) ? $clog2(NACK_LAT) : 1;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (start) begin
      wait_cnt_d = WAIT_W'(NACK_LAT - 1);
    end else if (run && (wait_cnt_q != '0)) begin
      wait_cnt_d = wait_cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign window = (wait_cnt_q == '0);

endmodule

// File: rtl/mshr_replay_stage.sv
// mshr_replay_stage
//   Holds one MSHR replay request, issues it to the D-cache data array,
//   waits NACK_LAT cycles for a possible nack and re-issues up to MAX_RETRY
//   times. The held branch mask is pruned every cycle by resolving branches;
//   a branch kill or LSU flush discards the request.
//   Ports: clock, reset (sync, active-low), io (mshr_replay_stage_if.slave).
//   Optional: `define MSHR_REPLAY_PERF_EN adds saturating 32-bit counters
//   io_perf_issued / io_perf_nacked / io_perf_killed.
module mshr_replay_stage
  import mshr_replay_pkg::*;
#(
  parameter int  NACK_LAT  = 2,
  parameter int  MAX_RETRY = 3,
  parameter type T         = req_t
) (
  input  logic                 clock,
  input  logic                 reset,
  mshr_replay_stage_if.slave   io
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  T                   held_q, held_d, held_upd;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               kill_pend_q, kill_pend_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic               killed_q, killed_d;
  logic               kill, fire, window;

  mshr_replay_nack_timer #(.NACK_LAT(NACK_LAT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .start  (fire),
    .run    (state_q == WAIT),
    .window (window)
  );

  always_comb begin
    held_upd             = held_q;
    held_upd.uop.br_mask = get_new_br_mask(io.io_brupdate, held_q.uop.br_mask);
    // Held contents are meaningless in IDLE, so gate the kill there.
    kill = (state_q != IDLE) && kill_now(io.io_brupdate, io.io_flush, held_q.uop);
    fire = (state_q == ISSUE) && !kill && io.io_out_ready;

    state_d     = state_q;
    held_d      = held_upd;
    retry_cnt_d = retry_cnt_q;
    kill_pend_d = kill_pend_q;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    killed_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.io_in_valid) begin
          held_d             = io.io_in_bits;
          held_d.uop.br_mask = get_new_br_mask(io.io_brupdate, io.io_in_bits.uop.br_mask);
          retry_cnt_d        = '0;
          kill_pend_d        = 1'b0;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (kill) begin
          killed_d = 1'b1;
          state_d  = IDLE;
        end else if (io.io_out_ready) begin
          kill_pend_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // A kill mid-window is only remembered; leaving early would let a
        // late nack be attributed to the next request.
        if (window) begin
          if (kill_pend_q || kill) begin
            killed_d = 1'b1;
            state_d  = IDLE;
          end else if (io.io_nack) begin
            if (retry_cnt_q < MAX_R) begin
              retry_cnt_d = retry_cnt_q + RETRY_W'(1);
              state_d     = ISSUE;
            end else begin
              drop_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          kill_pend_d = kill_pend_q | kill;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      retry_cnt_q <= '0;
      kill_pend_q <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      killed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      kill_pend_q <= kill_pend_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      killed_q    <= killed_d;
    end
  end

  always_ff @(posedge clock) begin
    held_q <= held_d;
  end

  assign io.io_in_ready  = reset && (state_q == IDLE);
  assign io.io_out_valid = (state_q == ISSUE) && !kill;
  assign io.io_out_bits  = held_upd;
  assign io.io_done      = done_q;
  assign io.io_drop      = drop_q;
  assign io.io_killed    = killed_q;
  assign io.io_busy      = (state_q != IDLE);

`ifdef MSHR_REPLAY_PERF_EN
  logic [PERF_CNT_W-1:0] perf_issued_q, perf_issued_d;
  logic [PERF_CNT_W-1:0] perf_nacked_q, perf_nacked_d;
  logic [PERF_CNT_W-1:0] perf_killed_q, perf_killed_d;
  logic                  nack_acc;

  always_comb begin
    nack_acc      = (state_q == WAIT) && window && !kill_pend_q && !kill && io.io_nack;
    perf_issued_d = fire     ? sat_inc(perf_issued_q) : perf_issued_q;
    perf_nacked_d = nack_acc ? sat_inc(perf_nacked_q) : perf_nacked_q;
    perf_killed_d = killed_q ? sat_inc(perf_killed_q) : perf_killed_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_nacked_q <= '0;
      perf_killed_q <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_nacked_q <= perf_nacked_d;
      perf_killed_q <= perf_killed_d;
    end
  end

  assign io.io_perf_issued = perf_issued_q;
  assign io.io_perf_nacked = perf_nacked_q;
  assign io.io_perf_killed = perf_killed_q;
`endif

endmodule

// File: tb/tb_mshr_replay_stage.sv
// tb_mshr_replay_stage
//   Directed and randomized stimulus for mshr_replay_stage. Expected values
//   come from a transaction-level walk of each request (issue attempts, a
//   NACK_LAT-cycle window, retry counting) driven by the bench's own inputs.
module tb_mshr_replay_stage;
  import mshr_replay_pkg::*;

  localparam int NACK_LAT  = 2;
  localparam int MAX_RETRY = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int checks   = 0;
  int failures = 0;

  int p_ready = 70;
  int p_nack  = 40;
  int p_flush = 5;
  int p_res   = 10;
  logic [BR_W-1:0] res_q[$];

  logic exp_done   = 1'b0;
  logic exp_drop   = 1'b0;
  logic exp_killed = 1'b0;

  int   fires;
  req_t rq;

  mshr_replay_stage_if io_if();

  mshr_replay_stage #(.NACK_LAT(NACK_LAT), .MAX_RETRY(MAX_RETRY)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io_if)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses();
    chk("pulses", {29'd0, io_if.io_done, io_if.io_drop, io_if.io_killed},
        {29'd0, exp_done, exp_drop, exp_killed});
    exp_done   = 1'b0;
    exp_drop   = 1'b0;
    exp_killed = 1'b0;
  endtask

  task automatic chk_held_phase();
    chk("held_in_ready", io_if.io_in_ready, 0);
    chk("held_busy", io_if.io_busy, 1);
    chk("held_pulses", {29'd0, io_if.io_done, io_if.io_drop, io_if.io_killed}, 0);
  endtask

  task automatic set_in(input logic vld, input req_t bits, input logic [BR_W-1:0] res,
                        input logic fl, input logic rdy, input logic nk);
    io_if.io_in_valid                 = vld;
    io_if.io_in_bits                  = bits;
    io_if.io_brupdate.b1.resolve_mask = res;
    io_if.io_flush                    = fl;
    io_if.io_out_ready                = rdy;
    io_if.io_nack                     = nk;
  endtask

  function automatic req_t rand_req();
    req_t q;
    q.uop.br_mask  = BR_W'($urandom & $urandom);
    q.uop.uses_ldq = 1'($urandom_range(1));
    q.uop.rob_idx  = 6'($urandom);
    q.addr         = $urandom;
    q.data         = $urandom;
    return q;
  endfunction

  task automatic drive_env(input logic vld, input req_t bits,
                           output logic [BR_W-1:0] res, output logic fl);
    logic [95:0] r;
    req_t        junk;
    logic        rdy, nk;
    r    = {$urandom, $urandom, $urandom};
    junk = r[$bits(req_t)-1:0];
    res  = '0;
    if (res_q.size() != 0) res = res_q.pop_front();
    else if ($urandom_range(99) < p_res) res[$urandom_range(BR_W-1)] = 1'b1;
    fl  = ($urandom_range(99) < p_flush);
    rdy = ($urandom_range(99) < p_ready);
    nk  = ($urandom_range(99) < p_nack);
    set_in(vld, vld ? bits : junk, res, fl, rdy, nk);
  endtask

  task automatic idle_cycle();
    logic [BR_W-1:0] res;
    logic fl;
    drive_env(1'b0, rq, res, fl);
    #1;
    chk("idle_in_ready", io_if.io_in_ready, 1);
    chk("idle_busy", io_if.io_busy, 0);
    chk("idle_out_valid", io_if.io_out_valid, 0);
    chk_pulses();
    @(negedge clock);
  endtask

  // Walks one request from accept to its final outcome; the outcome pulse
  // is left in exp_* for the following IDLE cycle to check.
  task automatic run_txn(input req_t r, output int obs_fires);
    logic [BR_W-1:0] mask, res;
    logic fl, kill, killed, rdy;
    int   retries, outcome, guard;
    obs_fires = 0;
    retries   = 0;
    outcome   = -1;
    drive_env(1'b1, r, res, fl);
    #1;
    chk("acc_in_ready", io_if.io_in_ready, 1);
    chk("acc_busy", io_if.io_busy, 0);
    chk("acc_out_valid", io_if.io_out_valid, 0);
    chk_pulses();
    mask = r.uop.br_mask & ~res;
    @(negedge clock);
    while (outcome < 0) begin
      rdy   = 1'b0;
      kill  = 1'b0;
      guard = 0;
      while (!rdy && !kill) begin
        drive_env(1'b0, r, res, fl);
        rdy  = io_if.io_out_ready;
        kill = ((mask & res) != '0) || (fl && r.uop.uses_ldq);
        #1;
        chk("iss_out_valid", io_if.io_out_valid, !kill);
        chk_held_phase();
        if (!kill) begin
          chk("iss_br_mask", io_if.io_out_bits.uop.br_mask, mask & ~res);
          chk("iss_addr", io_if.io_out_bits.addr, r.addr);
        end
        obs_fires += int'(io_if.io_out_valid && io_if.io_out_ready);
        mask &= ~res;
        @(negedge clock);
        guard++;
        if (guard > 200) begin
          chk("iss_guard", guard, 0);
          kill = 1'b1;
        end
      end
      if (kill) begin
        outcome = 2;
      end else begin
        killed = 1'b0;
        for (int i = 1; i <= NACK_LAT; i++) begin
          drive_env(1'b0, r, res, fl);
          killed |= ((mask & res) != '0) || (fl && r.uop.uses_ldq);
          #1;
          chk("wait_out_valid", io_if.io_out_valid, 0);
          chk_held_phase();
          obs_fires += int'(io_if.io_out_valid && io_if.io_out_ready);
          mask &= ~res;
          if (i == NACK_LAT) begin
            if (killed) outcome = 2;
            else if (io_if.io_nack) begin
              if (retries < MAX_RETRY) retries++;
              else outcome = 1;
            end else outcome = 0;
          end
          @(negedge clock);
        end
      end
    end
    exp_done   = (outcome == 0);
    exp_drop   = (outcome == 1);
    exp_killed = (outcome == 2);
  endtask

  initial begin
    rq = rand_req();
    set_in(1'b0, rq, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_in_ready", io_if.io_in_ready, 0);
    chk("reset_busy", io_if.io_busy, 0);
    chk("reset_out_valid", io_if.io_out_valid, 0);
    chk_pulses();
    @(negedge clock);
    reset = 1'b1;

    // Plain issue, no nack: fire in the first ISSUE cycle, done afterwards.
    p_res = 0; p_flush = 0; p_ready = 100; p_nack = 0;
    rq = rand_req(); rq.uop.br_mask = 8'h04;
    run_txn(rq, fires);
    chk("t1_fires", fires, 1);
    idle_cycle();

    // Nack on every window: MAX_RETRY+1 issues, then drop.
    p_nack = 100;
    rq = rand_req();
    run_txn(rq, fires);
    chk("t2_fires", fires, MAX_RETRY + 1);
    idle_cycle();

    // Kill in ISSUE while the data array is not ready.
    p_ready = 0; p_nack = 0;
    rq = rand_req(); rq.uop.br_mask = 8'h02;
    res_q.push_back(8'h00); res_q.push_back(8'h02);
    run_txn(rq, fires);
    chk("t3_fires", fires, 0);
    idle_cycle();

    // Kill in the first WAIT cycle, nack at the window: no re-issue.
    p_ready = 100; p_nack = 100;
    rq = rand_req(); rq.uop.br_mask = 8'h04;
    res_q.push_back(8'h00); res_q.push_back(8'h00); res_q.push_back(8'h04);
    run_txn(rq, fires);
    chk("t4_fires", fires, 1);
    idle_cycle();

    // Resolve on the accept cycle prunes the mask; flush spares non-LDQ uops.
    p_flush = 100; p_nack = 0;
    rq = rand_req(); rq.uop.br_mask = 8'h03; rq.uop.uses_ldq = 1'b0;
    res_q.push_back(8'h01);
    run_txn(rq, fires);
    chk("t5_fires", fires, 1);
    rq = rand_req(); rq.uop.uses_ldq = 1'b0;
    run_txn(rq, fires);
    idle_cycle();
    p_flush = 0;

    // Reset while waiting for the nack window abandons the request silently.
    rq = rand_req(); rq.uop.br_mask = '0;
    set_in(1'b1, rq, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rst_acc_ready", io_if.io_in_ready, 1);
    @(negedge clock);
    set_in(1'b0, rq, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rst_iss_valid", io_if.io_out_valid, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_wait_busy", io_if.io_busy, 1);
    chk("rst_in_ready_low", io_if.io_in_ready, 0);
    @(negedge clock);
    set_in(1'b0, rq, '0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rst_busy", io_if.io_busy, 0);
    chk("rst_in_ready", io_if.io_in_ready, 0);
    chk("rst_out_valid", io_if.io_out_valid, 0);
    chk_pulses();
    @(negedge clock);
    reset = 1'b1;
    set_in(1'b0, rq, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_rel_in_ready", io_if.io_in_ready, 1);
    chk_pulses();
    @(negedge clock);
    idle_cycle();

    // Randomized traffic, mixing back-to-back and spaced requests.
    p_ready = 70; p_nack = 40; p_flush = 5; p_res = 10;
    for (int n = 0; n < 60; n++) begin
      rq = rand_req();
      run_txn(rq, fires);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
